priority_encoder: RTL and testbench
===================================

# priority_encoder

Registered N-to-log2(N) priority encoder. Each enabled clock cycle it samples an N-bit request vector and reports the index of the highest-numbered asserted bit, together with a valid flag and a multiple-request flag. It sits between request-collection logic and any consumer that needs a binary index, such as an interrupt, arbiter or mux-select path.

## Interface
- N, default 8: request vector width; legal values are powers of two, 2 to 64.
- W, default 3: output index width; must equal log2(N).

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset. One clock; reset is synchronous and active-low.
- en  input  1  sample enable. When 1, outputs update at the clock edge; when 0, outputs hold.
- i  input  N  request vector; bit k is request k.
- o  output  W  index of the highest set bit of i, as sampled at the last enabled edge.
- valid  output  1  1 when the sampled i was nonzero.
- multi  output  1  1 when the sampled i had two or more bits set.

## Operation
- Priority: the highest index wins. Bit N-1 has the highest priority and bit 0 the lowest.
- Combinational next state, computed from i:
  - idx = largest k with i[k]=1;
  - any = OR of i;
  - many = two or more bits of i set.
- Zero input: idx = 0 and any = 0. The o value is then 0 but meaningless; consumers qualify o with valid.
- All three outputs (o, valid, multi) are registered. No combinational path exists from i to any output.
- Register update at a rising clk edge:
  - rst_n=0: o=0, valid=0, multi=0. Reset overrides en.
  - rst_n=1, en=1: o<=idx, valid<=any, multi<=many.
  - rst_n=1, en=0: o, valid and multi hold their values.
- Width rules:
  - o is unsigned, W bits.
  - No X propagation from i into the outputs is allowed when i is known.
  - multi is 0 whenever valid is 0.

## Timing
- Latency: 1 cycle. i sampled at edge t appears on the outputs immediately after edge t and stays stable until the next enabled edge.
- Reset value of every output: 0 (o=0, valid=0, multi=0).
- Reset is synchronous. Deasserting or asserting rst_n between edges has no effect until the next edge.
- Reset mid-operation: outputs clear at the first edge with rst_n=0. The first enabled edge after release loads fresh data.
- en and i may change every cycle. There is no handshake and no back-pressure.
- i is sampled only at enabled edges. Glitches between edges are ignored.
- Throughput: one result per cycle when en is held at 1.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with i=0xFF and en=1. Required: o=0, valid=0, multi=0 throughout. Release rst_n; one cycle later o=7, valid=1, multi=1.
- One-hot walk with en=1: apply i = 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x80 on consecutive cycles. Required: o = 0, 1, 2, 3, 4, 5, 6, 7 one cycle later each, with valid=1 and multi=0 on every result.
- Priority: apply i = 0x85, 0x06, 0x81, 0xFF. Required: o = 7, 2, 7, 7, with multi = 1, 1, 1, 1 and valid = 1.
- Zero input: apply i=0x00. Required, one cycle later: valid=0, multi=0, o=0.
- Enable hold: load i=0x10, giving o=4. Then set en=0 and drive i=0x80 for 3 cycles. Required: o stays 4 and valid stays 1. Set en=1; the next edge gives o=7.
- Reset mid-stream: while streaming the walk, pulse rst_n=0 for 1 cycle. Required: outputs are 0 for exactly that cycle, then the walk resumes with a 1-cycle latency.

Source files
------------

// File: rtl/priority_encoder_if.sv
// Request/result bundle for the registered priority encoder.
// The master drives the request vector and enable; the slave returns the registered index and flags.
interface priority_encoder_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic         en;
  logic [N-1:0] i;
  logic [W-1:0] o;
  logic         valid;
  logic         multi;

  modport master (output en, output i, input o, input valid, input multi);
  modport slave  (input en, input i, output o, output valid, output multi);
endinterface

// File: rtl/priority_encoder.sv
// Registered N-to-log2(N) priority encoder: highest set request bit wins.
// It also reports any-request (valid) and two-or-more-requests (multi), all with one-cycle latency.
module priority_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input logic               clk,
  input logic               rst_n,
  priority_encoder_if.slave bus
);

  if (W != $clog2(N)) begin : g_bad_width
    $error("priority_encoder: W must equal log2(N)");
  end

  // The upward scan lets later (higher) bits overwrite earlier ones, so the highest index wins.
  function automatic logic [W-1:0] highest_idx(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (v[k]) r = W'(k);
    end
    return r;
  endfunction

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  function automatic logic two_or_more(input logic [N-1:0] v);
    return |(v & (v - N'(1)));
  endfunction

  logic [W-1:0] o_p0;
  logic         vld_p0;
  logic         multi_p0;

  // Stage 0: sample the request vector on enabled edges
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_p0     <= '0;
      vld_p0   <= 1'b0;
      multi_p0 <= 1'b0;
    end else if (bus.en) begin
      o_p0     <= highest_idx(bus.i);
      vld_p0   <= |bus.i;
      multi_p0 <= two_or_more(bus.i);
    end
  end

  assign bus.o     = o_p0;
  assign bus.valid = vld_p0;
  assign bus.multi = multi_p0;

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder: table-driven vectors, hand-written corner sequences
// and a randomized stream, all checked through an expected-result queue.
module tb_priority_encoder;

  localparam int N = 8;
  localparam int W = 3;

  typedef struct {
    logic         rst_n;
    logic         en;
    logic [N-1:0] i;
    logic [W-1:0] o;
    logic         valid;
    logic         multi;
  } vec_t;

  typedef struct {
    logic [W-1:0] o;
    logic         valid;
    logic         multi;
    string        tag;
  } exp_t;

  logic clk;
  logic rst_n;

  priority_encoder_if #(.N(N), .W(W)) bus ();

  priority_encoder #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[$];

  // Reference model state
  logic [W-1:0] m_o;
  logic         m_valid;
  logic         m_multi;

  function automatic vec_t mk(input logic r, input logic e, input logic [N-1:0] v,
                              input logic [W-1:0] eo, input logic ev, input logic em);
    vec_t t;
    t.rst_n = r; t.en = e; t.i = v; t.o = eo; t.valid = ev; t.multi = em;
    return t;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [N-1:0] v);
    if (!r) begin
      m_o = '0; m_valid = 1'b0; m_multi = 1'b0;
    end else if (e) begin
      m_o = '0;
      for (int k = N - 1; k >= 0; k--) begin
        if (v[k]) begin
          m_o = W'(k);
          break;
        end
      end
      m_valid = (v != '0);
      m_multi = ($countones(v) >= 2);
    end
  endtask

  task automatic check1(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic compare_next();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    check1({e.tag, ".o"},     8'(bus.o),     8'(e.o));
    check1({e.tag, ".valid"}, 8'(bus.valid), 8'(e.valid));
    check1({e.tag, ".multi"}, 8'(bus.multi), 8'(e.multi));
  endtask

  // Drive one cycle, queue its expected result, then compare just after the edge.
  task automatic apply(input logic r, input logic e, input logic [N-1:0] v,
                       input logic [W-1:0] eo, input logic ev, input logic em,
                       input string tag);
    exp_t x;
    rst_n  = r;
    bus.en = e;
    bus.i  = v;
    model_step(r, e, v);
    x.o = eo; x.valid = ev; x.multi = em; x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    compare_next();
  endtask

  initial begin
    rst_n  = 1'b0;
    bus.en = 1'b0;
    bus.i  = '0;
    m_o = '0; m_valid = 1'b0; m_multi = 1'b0;

    // Reset with full request vector, then release
    vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 8'hFF, 3'd7, 1'b1, 1'b1));
    // One-hot walk
    for (int k = 0; k < N; k++)
      vecs.push_back(mk(1'b1, 1'b1, N'(1) << k, W'(k), 1'b1, 1'b0));
    // Priority among several requests
    vecs.push_back(mk(1'b1, 1'b1, 8'h85, 3'd7, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 8'h06, 3'd2, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 8'h81, 3'd7, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 8'hFF, 3'd7, 1'b1, 1'b1));
    // Zero input
    vecs.push_back(mk(1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0));
    // Lowest-priority pair, then reset overriding a low enable
    vecs.push_back(mk(1'b1, 1'b1, 8'h03, 3'd1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0));

    for (int n = 0; n < vecs.size(); n++)
      apply(vecs[n].rst_n, vecs[n].en, vecs[n].i, vecs[n].o, vecs[n].valid, vecs[n].multi,
            $sformatf("vec%0d", n));

    // Enable hold: outputs freeze while en is low
    apply(1'b1, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0, "hold_load");
    for (int n = 0; n < 3; n++)
      apply(1'b1, 1'b0, 8'h80, 3'd4, 1'b1, 1'b0, $sformatf("hold%0d", n));
    apply(1'b1, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0, "hold_release");

    // Reset pulse in the middle of a walk
    apply(1'b1, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0, "mid_w0");
    apply(1'b1, 1'b1, 8'h02, 3'd1, 1'b1, 1'b0, "mid_w1");
    apply(1'b0, 1'b1, 8'h04, 3'd0, 1'b0, 1'b0, "mid_rst");
    apply(1'b1, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0, "mid_w3");
    apply(1'b1, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0, "mid_w4");

    // Glitch on i between edges is not sampled
    rst_n  = 1'b1;
    bus.en = 1'b1;
    bus.i  = 8'hFF;
    #3;
    bus.i  = 8'h05;
    #1;
    apply(1'b1, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0, "glitch");

    // Randomized stream checked against the reference model
    for (int n = 0; n < 60; n++) begin
      logic         r;
      logic         e;
      logic [N-1:0] v;
      r = ($urandom_range(0, 15) != 0);
      e = ($urandom_range(0, 3) != 0);
      v = N'($urandom);
      if ($urandom_range(0, 4) == 0) v = N'(1) << $urandom_range(0, N - 1);
      if ($urandom_range(0, 9) == 0) v = '0;
      rst_n  = r;
      bus.en = e;
      bus.i  = v;
      model_step(r, e, v);
      sb.push_back('{o: m_o, valid: m_valid, multi: m_multi, tag: $sformatf("rnd%0d", n)});
      @(posedge clk);
      #1;
      compare_next();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
